// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment codes, digit-off pattern and parameter checks for the scan display
package seg_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Widest supported digit count is 8; callers slice to NUM_DIGITS
  localparam logic [7:0] DIG_OFF = 8'hFF;

  function automatic bit blank_cycles_ok(input int blank_cycles, input int scan_div);
    return (blank_cycles >= 1) && (blank_cycles < scan_div);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low 7-segment decoder, dash for illegal codes
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed common-anode 7-segment scanner with frame snapshot and dead time
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int CON_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CON_W-1:0]      CON_LAST  = CON_W'(SCAN_DIV - 1);
  localparam logic [CON_W-1:0]      CON_BLANK = CON_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

  if (!blank_cycles_ok(BLANK_CYCLES, SCAN_DIV)) begin : g_bad_blank
    $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < SCAN_DIV");
  end

  logic [CON_W-1:0]        con_q, con_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] frame_buf_q, frame_buf_d;
  logic                    lz_q, lz_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                    frame_done_q, frame_done_d;

  logic                    snap;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;
  logic                    upper_zero;
  logic                    blank_digit;

  always_comb begin
    con_d = con_q + 1'b1;
    idx_d = idx_q;
    if (con_q == CON_LAST) begin
      con_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Snapshot only at the very start of a frame so a mid-frame change cannot tear
    snap        = (con_q == '0) && (idx_q == '0);
    frame_buf_d = snap ? bcd_in : frame_buf_q;
    lz_d        = snap ? lz_blank : lz_q;
  end

  assign cur_digit = frame_buf_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // A digit is a leading zero when it and every more-significant digit are exactly 0
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_q) && frame_buf_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  assign blank_digit = lz_q && (idx_q != '0) && upper_zero;

  always_comb begin
    seg_d     = SEG_OFF;
    dig_sel_d = DIG_OFF[NUM_DIGITS-1:0];
    if (con_q >= CON_BLANK) begin
      dig_sel_d = ~(ONE_HOT0 << idx_q);
      seg_d     = blank_digit ? SEG_OFF : dec_seg;
    end
    frame_done_d = (con_q == CON_LAST) && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      con_q        <= '0;
      idx_q        <= '0;
      frame_buf_q  <= '0;
      lz_q         <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_sel_q    <= DIG_OFF[NUM_DIGITS-1:0];
      frame_done_q <= 1'b0;
    end else begin
      con_q        <= con_d;
      idx_q        <= idx_d;
      frame_buf_q  <= frame_buf_d;
      lz_q         <= lz_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display against a cycle-count reference model
module tb_seg_scan_display;

  localparam int N     = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * SD;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [15:0] bcd_in = 16'h0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       fd;
    int         n;
  } exp_t;

  exp_t        sb_q[$];
  int          t = 0;
  int          step_no = 0;
  logic [15:0] snap = 16'h0;
  logic        snap_lz = 1'b0;
  logic [6:0]  dec_tbl [16];

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .res        (res),
    .bcd_in     (bcd_in),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  // Model: position in the frame follows purely from cycles elapsed since reset release
  task automatic step(input logic r, input logic [15:0] b, input logic lz);
    exp_t        e;
    int          con;
    int          idx;
    logic [15:0] sh;
    @(negedge clk);
    res      = r;
    bcd_in   = b;
    lz_blank = lz;
    step_no++;
    e.n  = step_no;
    e.fd = 1'b0;
    if (r) begin
      e.seg = 7'h7F;
      e.dig = 4'hF;
      t = 0;
    end else begin
      if (t % FRAME == 0) begin
        snap    = b;
        snap_lz = lz;
      end
      con = t % SD;
      idx = (t / SD) % N;
      if (con < BC) begin
        e.seg = 7'h7F;
        e.dig = 4'hF;
      end else begin
        e.dig = ~(4'b0001 << idx);
        sh = snap >> (4 * idx);
        if (snap_lz && idx >= 1 && sh == 16'h0) e.seg = 7'h7F;
        else e.seg = dec_tbl[sh[3:0]];
      end
      e.fd = ((t % FRAME) == FRAME - 1);
      t++;
    end
    sb_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [15:0] b, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, b, lz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (seg !== e.seg || dig_sel !== e.dig || frame_done !== e.fd) begin
          errors++;
          $display("FAIL out step %0d: got seg=%h dig_sel=%h frame_done=%b, expected seg=%h dig_sel=%h frame_done=%b",
                   e.n, seg, dig_sel, frame_done, e.seg, e.dig, e.fd);
        end
      end
    end
  end

  initial begin : stim
    logic [15:0] rb;
    logic        rlz;
    logic        rr;
    dec_tbl[0] = 7'h40; dec_tbl[1] = 7'h79; dec_tbl[2] = 7'h24; dec_tbl[3] = 7'h30;
    dec_tbl[4] = 7'h19; dec_tbl[5] = 7'h12; dec_tbl[6] = 7'h02; dec_tbl[7] = 7'h78;
    dec_tbl[8] = 7'h00; dec_tbl[9] = 7'h10;
    for (int i = 10; i < 16; i++) dec_tbl[i] = 7'h3F;

    for (int i = 0; i < 5; i++) step(1'b1, 16'h1234, 1'b0);

    // Basic scan then a mid-frame change at E12 that must wait for frame 2
    run(11, 16'h1234, 1'b0);
    run(60, 16'h5678, 1'b0);

    step(1'b1, 16'h0070, 1'b1);
    run(FRAME, 16'h0070, 1'b1);
    run(FRAME, 16'h0000, 1'b1);
    run(FRAME, 16'h0A0C, 1'b1);

    // Reset at E20, then the opening pattern must repeat
    step(1'b1, 16'h1234, 1'b0);
    run(19, 16'h1234, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    run(40, 16'h1234, 1'b0);

    rb  = 16'h1234;
    rlz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < 4; k++)
          rb[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 63) == 0) rlz = ~rlz;
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rb, rlz);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Reader side of the BCD seconds digits produced by the seconds counter.
- Takes NUM_DIGITS packed BCD digits and drives a time-multiplexed, common-anode 7-segment display. Segment and digit-select outputs are both active-low.
- Snapshots the digit bus once per frame so a digit change mid-frame cannot tear the display. Inserts a dead-time blank at the start of every digit slot to stop ghosting.
- Sits between the counter datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- SCAN_DIV, 24000: clk cycles per digit slot. At 24 MHz this gives 1 kHz per digit.
- BLANK_CYCLES, 240: cycles at the start of each slot with all outputs off. Legal range is 1 <= BLANK_CYCLES < SCAN_DIV.

Ports:
- clk, input, 1: system clock.
- res, input, 1: reset. Synchronous, active-high.
- bcd_in, input, 4*NUM_DIGITS: packed digits. Digit i = bcd_in[4i+3:4i]. Digit 0 is least significant and is shown on dig_sel[0].
- lz_blank, input, 1: 1 = suppress leading zeros. Sampled together with the frame snapshot.
- seg, output, 7: {g,f,e,d,c,b,a}, active-low, registered.
- dig_sel, output, NUM_DIGITS: one-cold digit enable, registered.
- frame_done, output, 1: one-cycle pulse at the end of each full scan frame.

Behaviour:
- Clock and reset: one clock. res is synchronous and active-high; all registers are sampled on posedge clk.
- Reset values:
  - con_t = 0, idx = 0, frame_buf = 0, lz_reg = 0.
  - seg = 7'h7F, dig_sel = all ones, frame_done = 0.
- Slot counter con_t:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1: con_t <= 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
- Snapshot: on the edge where con_t==0 and idx==0, frame_buf <= bcd_in and lz_reg <= lz_blank. No other update occurs. Changes on bcd_in take effect at the next frame.
- Output register on every edge, computed from the pre-edge con_t, idx and frame_buf:
  - If con_t < BLANK_CYCLES: seg = 7'h7F and dig_sel = all ones.
  - Otherwise: dig_sel = ~(1 << idx) and seg = decode(frame_buf digit idx), subject to blanking.
- Latency: outputs lag con_t by one cycle.
  - Each digit is driven for exactly SCAN_DIV - BLANK_CYCLES cycles.
  - A frame is NUM_DIGITS*SCAN_DIV cycles.
- Decode, active-low, seg = gfedcba:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19.
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Values 10..15 (illegal BCD) show a dash: 3F.
- Leading-zero blanking: when lz_reg = 1, digit i (i >= 1) is blank if digit i and every more-significant digit are 0.
  - A blanked digit drives seg = 7F; its dig_sel bit is still asserted.
  - Digit 0 is never blanked.
  - An illegal digit counts as nonzero.
- frame_done: registered high for one cycle after the edge where con_t==SCAN_DIV-1 and idx==NUM_DIGITS-1.
- Reset mid-frame: the next cycle returns to the reset values. The first edge after res falls takes a fresh snapshot, and the display restarts at digit 0 in its blank phase.

Decomposition:
- Package seg_pkg holds:
  - the segment code constants for 0-9, DASH and OFF;
  - the DIG_OFF pattern;
  - a parameter-legality check for BLANK_CYCLES.
- Sub-module bcd_to_seg7: purely combinational 4-bit to 7-bit active-low decoder implementing the table above. It is instantiated once, on the selected digit.
- The scan, snapshot and output registers stay in seg_scan_display.

Test Plan:
All tests use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2. Edges are numbered E1, E2, ... counting from the first edge with res=0.
1. Reset: res=1 for 5 cycles with bcd_in=16'h1234 -> seg=7F, dig_sel=F, frame_done=0 throughout.
2. Basic scan: bcd_in=16'h1234, lz_blank=0, release reset.
   - E1-E2: outputs blank.
   - E3-E8: dig_sel=E, seg=19.
   - E9-E10: blank.
   - E11-E16: dig_sel=D, seg=30.
   - Then digit 2 shows 24 and digit 3 shows 79.
   - frame_done is high for one cycle after E32 only.
3. No tearing: bcd_in changes 16'h1234 -> 16'h5678 at E12 -> frame 1 still shows 4,3,2,1. Frame 2 (E33 onward) shows 8,7,6,5.
4. Leading zeros: bcd_in=16'h0070, lz_blank=1 -> digit0 = 40, digit1 = 78, digit2 = 7F, digit3 = 7F. With 16'h0000, only digit0 shows 40.
5. Illegal BCD: bcd_in=16'h0A0C, lz_blank=1 -> digit0 = 3F, digit1 = 40 (not blanked, because the more-significant A is nonzero), digit2 = 3F, digit3 = 7F.
6. Reset mid-frame: assert res at E20 for 1 cycle -> outputs 7F/F the next cycle. After release, the E1-E8 pattern of test 2 repeats exactly.
